tone_decoder: RTL and testbench

Receive-side counterpart of the speaker tone generator. Measures the half-period of an incoming square-wave tone (toggle-per-half-period format, 100 MHz clock) and decodes it back into the (octave, note) code that produced it. Used for loopback self-test of the piano output path and for inter-board note transfer. Outputs drive the display/recorder logic.

---
 rtl/tone_decoder.sv | 153 +++++++++++++++
 tb/tb_tone_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// Tone decoder: measures the half-period of a toggling square wave and maps it
// back to the (octave, note) code of the speaker tone generator.
module tone_decoder #(
    parameter int unsigned TOL_SHIFT    = 6,
    parameter int unsigned STABLE_COUNT = 4,
    parameter int unsigned TIMEOUT      = 3200000,
    parameter int unsigned MIN_PERIOD   = 64,
    // Extra right shift on every table entry; 0 for real generator tones.
    parameter int unsigned TABLE_SHIFT  = 0
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic       ain,
    output logic [2:0] octave,
    output logic [2:0] note,
    output logic       valid,
    output logic       note_chg
);
    localparam int SW = $clog2(STABLE_COUNT + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, EVAL} state_t;

    state_t        state;
    logic [2:0]    sync;
    logic [31:0]   cnt;
    logic [31:0]   period_reg;
    logic          armed;
    logic [2:0]    idx_oct;
    logic [2:0]    idx_note;
    logic [5:0]    result;
    logic [5:0]    cand;
    logic [SW-1:0] stable;

    logic          ain_edge;
    logic          timeout;
    logic          hit;
    logic          last_idx;
    logic          do_update;
    logic [31:0]   base;
    logic [31:0]   target;
    logic [31:0]   diff;

    assign ain_edge  = sync[2] ^ sync[1];
    // An edge in the same cycle always beats the timeout.
    assign timeout   = !ain_edge && (cnt == TIMEOUT);
    assign last_idx  = (idx_oct == 3'd7) && (idx_note == 3'd7);
    assign do_update = (stable == SW'(STABLE_COUNT)) &&
                       (!valid || (cand != {octave, note})) && !timeout;

    always_comb begin
        case (idx_note)
            3'd1:    base = 32'd1528902;
            3'd2:    base = 32'd1362097;
            3'd3:    base = 32'd1213491;
            3'd4:    base = 32'd1145383;
            3'd5:    base = 32'd1020420;
            3'd6:    base = 32'd909091;
            3'd7:    base = 32'd809908;
            default: base = 32'd0;
        endcase
    end

    assign target = base >> (32'(idx_oct) + TABLE_SHIFT);
    assign diff   = (period_reg >= target) ? (period_reg - target) : (target - period_reg);
    assign hit    = (period_reg >= MIN_PERIOD) && (diff <= (target >> TOL_SHIFT));

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sync       <= 3'd0;
            cnt        <= 32'd0;
            period_reg <= 32'd0;
            armed      <= 1'b0;
            idx_oct    <= 3'd0;
            idx_note   <= 3'd0;
            result     <= 6'd0;
            cand       <= 6'd0;
            stable     <= '0;
            octave     <= 3'd0;
            note       <= 3'd0;
            valid      <= 1'b0;
            note_chg   <= 1'b0;
        end else begin
            note_chg <= 1'b0;
            sync     <= {sync[1:0], ain};

            if (ain_edge) begin
                period_reg <= cnt;
                cnt        <= 32'd1;
            end else if (cnt < TIMEOUT) begin
                cnt <= cnt + 32'd1;
            end

            case (state)
                IDLE: state <= IDLE;
                SEARCH: begin
                    if (hit || last_idx) begin
                        result <= hit ? {idx_oct, idx_note} : 6'd0;
                        state  <= EVAL;
                    end else if (idx_note == 3'd7) begin
                        idx_oct  <= idx_oct + 3'd1;
                        idx_note <= 3'd1;
                    end else begin
                        idx_note <= idx_note + 3'd1;
                    end
                end
                EVAL: begin
                    if (result == 6'd0) begin
                        stable <= '0;
                        cand   <= 6'd0;
                    end else if (result == cand) begin
                        if (stable < SW'(STABLE_COUNT))
                            stable <= stable + SW'(1);
                    end else begin
                        cand   <= result;
                        stable <= SW'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A new edge abandons any scan in progress and starts over.
            if (ain_edge) begin
                if (armed) begin
                    state    <= SEARCH;
                    idx_oct  <= 3'd0;
                    idx_note <= 3'd1;
                end
                armed <= 1'b1;
            end

            if (do_update) begin
                octave   <= cand[5:3];
                note     <= cand[2:0];
                valid    <= 1'b1;
                note_chg <= 1'b1;
            end

            if (timeout) begin
                armed  <= 1'b0;
                stable <= '0;
                state  <= IDLE;
                if (valid) begin
                    octave   <= 3'd0;
                    note     <= 3'd0;
                    valid    <= 1'b0;
                    note_chg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: directed tone sequences, a per-cycle reference model
// of the decoded outputs, and literal checkpoints after each phase.
module tb_tone_decoder;
    localparam int unsigned TIMEOUT     = 4000;
    localparam int unsigned TABLE_SHIFT = 3;
    localparam int          SETTLE      = 80;
    localparam int unsigned BASE [7] = '{1528902, 1362097, 1213491, 1145383,
                                         1020420, 909091, 809908};

    logic       clk = 1'b0;
    logic       rst;
    logic       ain;
    logic [2:0] octave;
    logic [2:0] note;
    logic       valid;
    logic       note_chg;

    int checks = 0;
    int errors = 0;

    tone_decoder #(
        .TOL_SHIFT(6), .STABLE_COUNT(4), .TIMEOUT(TIMEOUT),
        .MIN_PERIOD(64), .TABLE_SHIFT(TABLE_SHIFT)
    ) dut (
        .clk_100M(clk), .rst(rst), .ain(ain),
        .octave(octave), .note(note), .valid(valid), .note_chg(note_chg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // First (octave, note) whose target lies within target/64 of p, scanning
    // octave-major; idx is the scan position (55 when nothing matches).
    function automatic void decode(input int unsigned p, output logic [5:0] code, output int idx);
        code = 6'd0;
        idx  = 55;
        for (int o = 0; o < 8; o++) begin
            for (int n = 1; n <= 7; n++) begin
                int unsigned t;
                int unsigned d;
                t = BASE[n-1] >> (o + TABLE_SHIFT);
                d = (p > t) ? (p - t) : (t - p);
                if (code == 6'd0 && p >= 64 && d <= (t >> 6)) begin
                    code = {3'(o), 3'(n)};
                    idx  = o * 7 + n - 1;
                end
            end
        end
    endfunction

    logic [5:0] hist[$];
    logic [5:0] m_out = 6'd0;
    logic [5:0] m_pend_res;
    logic       m_valid = 1'b0;
    logic       m_armed = 1'b0;
    logic       m_prev = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_to_done = 1'b0;
    int         m_pend_c, m_pend_idx;
    int         cyc = 0;
    int         m_last = 0;
    int         rst_cyc = 0;
    int         m_pulses = 0;
    int         dut_pulses = 0;

    function automatic bit hist_stable();
        if (hist.size() < 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (hist[i] == 6'd0 || hist[i] != hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        int  el;
        logic [5:0] code;
        int  idx;
        cyc++;
        if (rst) begin
            hist.delete();
            m_out = 6'd0; m_valid = 1'b0; m_armed = 1'b0; m_prev = 1'b0;
            m_pend = 1'b0; m_to_done = 1'b0; m_last = cyc; rst_cyc = cyc;
        end else begin
            if (note_chg === 1'b1) dut_pulses++;
            if (m_pend && (cyc - m_pend_c > m_pend_idx + 1)) begin
                m_pend = 1'b0;
                hist.push_back(m_pend_res);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist_stable() && (!m_valid || hist[0] != m_out)) begin
                    m_out = hist[0]; m_valid = 1'b1; m_pulses++;
                end
            end
            if (ain !== m_prev) begin
                m_prev = ain;
                if (m_armed) begin
                    decode(cyc - m_last, code, idx);
                    m_pend = 1'b1; m_pend_c = cyc; m_pend_res = code; m_pend_idx = idx;
                end
                m_armed = 1'b1; m_last = cyc; m_to_done = 1'b0;
            end else if (!m_to_done && (cyc - m_last >= int'(TIMEOUT))) begin
                m_to_done = 1'b1; m_armed = 1'b0; hist.delete();
                if (m_valid) begin
                    m_valid = 1'b0; m_out = 6'd0; m_pulses++;
                end
            end
            el = cyc - m_last;
            if ((cyc - rst_cyc > SETTLE) && (el > SETTLE) &&
                !(el >= int'(TIMEOUT) - 10 && el <= int'(TIMEOUT) + 10)) begin
                check("outputs{valid,oct,note}", {valid, octave, note}, {m_valid, m_out});
                check("note_chg pulse count", dut_pulses, m_pulses);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic half(input int n);
        repeat (n) @(posedge clk);
        #2 ain = ~ain;
    endtask

    task automatic tone(input int n, input int count);
        for (int i = 0; i < count; i++) half(n);
    endtask

    // Waits 100 cycles into the current half-period, then checks literals.
    task automatic expect_state(input string tag, input logic [2:0] o, input logic [2:0] n,
                                input logic v, input int p);
        repeat (100) @(posedge clk);
        #1;
        check({tag, " octave"}, octave, o);
        check({tag, " note"}, note, n);
        check({tag, " valid"}, valid, v);
        check({tag, " pulses"}, dut_pulses, p);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        ain = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset octave", octave, 3'd0);
        check("reset note", note, 3'd0);
        check("reset valid", valid, 1'b0);
        check("reset note_chg", note_chg, 1'b0);

        // C7 = 1528902>>10 = 1493: arming edge plus four matches
        tone(1493, 5);
        expect_state("C7", 3'd7, 3'd1, 1'b1, 1);
        half(1393);
        half(1493);

        // B7 = 809908>>10 = 790: C7 held until the fourth B7 match
        tone(790, 4);
        expect_state("B7", 3'd7, 3'd7, 1'b1, 2);
        half(690);

        // A6 = 909091>>9 = 1775, window +-27
        tone(1775, 4);
        expect_state("A6", 3'd6, 3'd6, 1'b1, 3);
        half(1675);
        half(1802);
        half(1803);
        tone(1775, 4);
        expect_state("A6 window edge", 3'd6, 3'd6, 1'b1, 3);
        half(1675);

        // 10-cycle glitch inside one A6 half-period
        half(700);
        half(10);
        half(1065);
        tone(1775, 4);
        expect_state("A6 after glitch", 3'd6, 3'd6, 1'b1, 3);

        // silence: timeout clears the outputs
        repeat (TIMEOUT) @(posedge clk);
        expect_state("timeout", 3'd0, 3'd0, 1'b0, 4);

        tone(790, 5);
        expect_state("B7 restart", 3'd7, 3'd7, 1'b1, 5);
        half(690);

        // non-matching period launches a full scan; reset lands mid-scan
        half(1050);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async reset octave", octave, 3'd0);
        check("async reset note", note, 3'd0);
        check("async reset valid", valid, 1'b0);
        check("async reset note_chg", note_chg, 1'b0);
        ain = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // first edge lands ~1775 cycles after reset but must only arm
        tone(1775, 4);
        expect_state("post-reset arm only", 3'd0, 3'd0, 1'b0, 5);
        half(1675);
        expect_state("post-reset A6", 3'd6, 3'd6, 1'b1, 6);

        repeat (200) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
